// File: rtl/noc_pack_pkg.sv
// Shared types and header-field layout for the NOC byte packer.
// Build option NOC_PACK_BIGEND_EN (used by noc_byte_packer) selects big-endian byte packing.
package noc_pack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    localparam logic [2:0] OP_WRITE = 3'b001;

    localparam int HDR_OP_MSB = 7;
    localparam int HDR_OP_LSB = 5;
    localparam int HDR_N_MSB  = 4;
    localparam int HDR_N_LSB  = 0;

    localparam int WORD_W = 64;

    // A header is legal only for a write of 1..max_n whole words.
    function automatic logic hdr_legal(input logic [7:0] hdr, input logic [4:0] max_n);
        logic [2:0] op;
        logic [4:0] n;
        op = hdr[HDR_OP_MSB:HDR_OP_LSB];
        n  = hdr[HDR_N_MSB:HDR_N_LSB];
        return (op == OP_WRITE) && (n != 5'd0) && (n <= max_n);
    endfunction

endpackage

// File: rtl/noc_pack_fifo.sv
// Word buffer for the byte packer: first-word-fall-through with a registered head.
// A write into a full buffer is accepted only if a pop happens in the same cycle; otherwise drop_o pulses.
module noc_pack_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [AW:0]      remain;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             pop, push;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign pop       = rd_en_i && !empty_o;
    assign push      = wr_en_i && (!full_o || pop);
    assign drop_o    = wr_en_i && !push;
    assign rd_data_o = rd_data_q;

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        remain  = count_q - {{AW{1'b0}}, pop};
        // The head register is preloaded with whatever will sit at the head next cycle.
        if (count_d == '0) begin
            rd_data_d = '0;
        end else if (remain == '0) begin
            rd_data_d = wr_data_i;
        end else begin
            rd_data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/noc_byte_packer.sv
// Packs NOC header/payload bytes into 64-bit words and queues them for the permutation stage.
// Define NOC_PACK_BIGEND_EN to place the first byte of each word in din[63:56].
module noc_byte_packer
    import noc_pack_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WORDS  = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        noc_to_dev_ctl,
    input  logic [7:0]  noc_to_dev_data,
    output logic        pushin,
    output logic        firstin,
    output logic [63:0] din,
    input  logic        stopin,
    output logic        err_hdr,
    output logic        err_ovf,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a word moves downstream on a cycle where pushin && !stopin;
    // while stopin is high, pushin/firstin/din hold. The NOC side never stalls.

    state_e        state_q, state_d;
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    logic [4:0]    word_cnt_q, word_cnt_d;
    logic [4:0]    n_q, n_d;
    logic [63:0]   acc_q, acc_d;
    logic          err_hdr_q, err_hdr_d;
    logic          err_ovf_q, err_ovf_d;

    logic          hdr_ok;
    logic [2:0]    lane;
    logic [63:0]   word_next;
    logic          wr_en;
    logic [64:0]   wr_data;
    logic [64:0]   rd_data;
    logic          fifo_full, fifo_empty, fifo_drop;
    logic          pop;

    assign hdr_ok = hdr_legal(noc_to_dev_data, 5'(MAX_WORDS));

`ifdef NOC_PACK_BIGEND_EN
    assign lane = ~byte_cnt_q;
`else
    assign lane = byte_cnt_q;
`endif

    always_comb begin
        word_next = acc_q;
        word_next[{lane, 3'b000} +: 8] = noc_to_dev_data;
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        n_d        = n_q;
        acc_d      = acc_q;
        err_hdr_d  = 1'b0;
        wr_en      = 1'b0;
        wr_data    = {(word_cnt_q == 5'd0), word_next};

        if (noc_to_dev_ctl) begin
            // Any header byte is decoded; one arriving mid-frame also aborts that frame.
            err_hdr_d = !hdr_ok || (state_q == ST_COLLECT);
            if (hdr_ok) begin
                state_d    = ST_COLLECT;
                byte_cnt_d = 3'd0;
                word_cnt_d = 5'd0;
                n_d        = noc_to_dev_data[HDR_N_MSB:HDR_N_LSB];
                acc_d      = '0;
            end else begin
                state_d = ST_DISCARD;
                acc_d   = '0;
            end
        end else if (state_q == ST_COLLECT) begin
            acc_d      = word_next;
            byte_cnt_d = byte_cnt_q + 3'd1;
            if (byte_cnt_q == 3'd7) begin
                wr_en      = 1'b1;
                acc_d      = '0;
                word_cnt_d = word_cnt_q + 5'd1;
                if (word_cnt_q == n_q - 5'd1) state_d = ST_IDLE;
            end
        end

        err_ovf_d = err_ovf_q | fifo_drop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            n_q        <= '0;
            acc_q      <= '0;
            err_hdr_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            n_q        <= n_d;
            acc_q      <= acc_d;
            err_hdr_q  <= err_hdr_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    assign pop = pushin && !stopin;

    noc_pack_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (65)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (pop),
        .rd_data_o (rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .drop_o    (fifo_drop)
    );

    assign pushin      = !fifo_empty;
    assign firstin     = rd_data[64];
    assign din         = rd_data[63:0];
    assign err_hdr     = err_hdr_q;
    assign err_ovf     = err_ovf_q;
    assign dbg_state_o = state_q;

endmodule
